// File: rtl/serial_add_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : serial_add_sequencer_pkg                                          |
// | Brief  : Shared state encoding and size helpers for serial sequencers.     |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package serial_add_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter needs at least one bit even when a single digit covers the word.
    function automatic int calc_cnt_w(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_sequencer_ripple_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ripple_slice                                                      |
// | Brief  : Combinational DIGIT-bit ripple-carry adder slice.                 |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module ripple_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_carry;

    assign w_carry[0] = c_in;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign c_out    = w_carry[DIGIT];
    assign c_msb_in = w_carry[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/serial_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : serial_add_sequencer                                              |
// | Brief  : Digit-serial adder: one DIGIT-bit slice reused over WIDTH/DIGIT   |
// |          cycles, with valid/ready request and result handshakes.           |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(NDIG);

    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(NDIG - 1);

    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_width
        $error("serial_add_sequencer: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT-1:0] w_slice_sum;
    logic             w_slice_c_out;
    logic             w_slice_c_msb_in;
    logic [WIDTH-1:0] w_sum_next;

    ripple_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a        (r_a_sh[DIGIT-1:0]),
        .b        (r_b_sh[DIGIT-1:0]),
        .c_in     (r_carry),
        .sum      (w_slice_sum),
        .c_out    (w_slice_c_out),
        .c_msb_in (w_slice_c_msb_in)
    );

    // New digit enters at the top so the LSB digit lands at bit 0 after NDIG shifts.
    if (NDIG == 1) begin : g_single_digit
        assign w_sum_next = w_slice_sum;
    end else begin : g_multi_digit
        assign w_sum_next = {w_slice_sum, r_sum[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt == C_CNT_LAST) begin
                    w_last       = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sh  <= r_a_sh >> DIGIT;
            r_b_sh  <= r_b_sh >> DIGIT;
            r_sum   <= w_sum_next;
            r_carry <= w_slice_c_out;
            r_cnt   <= r_cnt + C_CNT_ONE;
            if (w_last) begin
                r_c_out <= w_slice_c_out;
                r_ovf   <= w_slice_c_msb_in ^ w_slice_c_out;
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_serial_add_sequencer                                           |
// | Brief  : Scoreboard bench for serial_add_sequencer (16/4 and 4/4 builds).  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_serial_add_sequencer;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf, busy;
    logic [15:0] a, b, sum;

    logic       v4_in_valid, v4_in_ready, v4_c_in, v4_out_valid, v4_out_ready;
    logic       v4_c_out, v4_ovf, v4_busy;
    logic [3:0] v4_a, v4_b, v4_sum;

    always #5 clk = ~clk;

    serial_add_sequencer #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
    );

    serial_add_sequencer #(.WIDTH(4), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
        .a(v4_a), .b(v4_b), .c_in(v4_c_in), .out_valid(v4_out_valid),
        .out_ready(v4_out_ready), .sum(v4_sum), .c_out(v4_c_out), .ovf(v4_ovf),
        .busy(v4_busy)
    );

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   last_acc = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares whatever the DUT presents against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    check("latency_edge", edge_cnt, sb[0].acc + NDIG);
                end
            end
            if (out_valid) begin
                check("in_ready_in_done", {31'd0, in_ready}, 0);
                check("busy_in_done", {31'd0, busy}, 1);
                if (sb.size() != 0) begin
                    check("sum", {16'd0, sum}, {16'd0, sb[0].sum});
                    check("c_out", {31'd0, c_out}, {31'd0, sb[0].c});
                    check("ovf", {31'd0, ovf}, {31'd0, sb[0].ovf});
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic [15:0] es, input logic ec, input logic eo);
        int   n;
        exp_t e;
        n = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        c_in = tc;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            return;
        end
        e.sum = es;
        e.c   = ec;
        e.ovf = eo;
        e.acc = edge_cnt + 1;
        last_acc = e.acc;
        sb.push_back(e);
        step();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("drain_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int prev_acc;
        in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
        v4_in_valid = 1'b0; v4_a = '0; v4_b = '0; v4_c_in = 1'b0; v4_out_ready = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_sum", {16'd0, sum}, 0);
        check("rst_flags", {30'd0, c_out, ovf}, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_done();
        send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        in_valid = 1'b0;
        wait_done();
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_done();
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_done();

        // Backpressure with a competing request that must not be taken.
        out_ready = 1'b0;
        send(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
        in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            a = 16'(n * 16'h1111); b = 16'hBEEF; step(); n++;
        end
        check("bp_out_valid_seen", {31'd0, out_valid}, 1);
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            step();
            check("bp_in_ready", {31'd0, in_ready}, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_in_ready", {31'd0, in_ready}, 1);
        check("bp_sb_drained", sb.size(), 0);

        // Asynchronous reset two digits into an operation.
        send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        in_valid = 1'b0;
        step(); step();
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 1);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_sum", {16'd0, sum}, 0);
        step();
        rst_n = 1'b1;
        step();
        send(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_done();

        // Back-to-back requests with the consumer always ready.
        prev_acc = 0;
        for (int i = 0; i < 3; i++) begin
            send(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);
            if (i > 0) check("b2b_spacing", last_acc - prev_acc, NDIG + 2);
            prev_acc = last_acc;
        end
        in_valid = 1'b0;
        wait_done();

        // Single-digit build: result one edge after accept.
        v4_in_valid = 1'b1; v4_a = 4'h9; v4_b = 4'h8; v4_c_in = 1'b0;
        step();
        v4_in_valid = 1'b0;
        check("w4_out_valid_run", {31'd0, v4_out_valid}, 0);
        check("w4_busy_run", {31'd0, v4_busy}, 1);
        step();
        check("w4_out_valid", {31'd0, v4_out_valid}, 1);
        check("w4_sum", {28'd0, v4_sum}, 32'h1);
        check("w4_c_out", {31'd0, v4_c_out}, 1);
        check("w4_ovf", {31'd0, v4_ovf}, 1);
        step();
        check("w4_in_ready", {31'd0, v4_in_ready}, 1);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
